// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// master = upstream source / downstream sink side, slave = the adder.
interface pipelined_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, op_sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Segmented-carry add/subtract pipeline with valid/ready backpressure.
// Optional macro ADDSUB_SATURATE_EN clamps overflowed results to the signed limit.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_addsub_if.slave bus
);
    localparam int SEG = WIDTH / STAGES;
    localparam int MSB = WIDTH - 1;

    // st_* is the view each stage consumes: ports for stage 0, previous stage registers otherwise
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_s [STAGES];
    logic             st_c [STAGES];
    logic             st_v [STAGES];

    logic             adv;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             valid_q;

    assign adv           = bus.out_ready || !valid_q;
    assign bus.in_ready  = adv;
    assign bus.out_valid = valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    assign st_a[0] = bus.a;
    assign st_b[0] = bus.op_sub ? ~bus.b : bus.b;
    assign st_s[0] = '0;
    assign st_c[0] = bus.cin ^ bus.op_sub;
    assign st_v[0] = bus.in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG:0]     seg_add;
        logic [WIDTH-1:0] s_next;

        always_comb begin
            seg_add = {1'b0, st_a[k][k*SEG +: SEG]} + {1'b0, st_b[k][k*SEG +: SEG]}
                    + {{SEG{1'b0}}, st_c[k]};
            s_next = st_s[k];
            s_next[k*SEG +: SEG] = seg_add[SEG-1:0];
        end

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;
            logic             c_q;
            logic             v_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (adv) begin
                    a_q <= st_a[k];
                    b_q <= st_b[k];
                    s_q <= s_next;
                    c_q <= seg_add[SEG];
                    v_q <= st_v[k];
                end
            end

            assign st_a[k+1] = a_q;
            assign st_b[k+1] = b_q;
            assign st_s[k+1] = s_q;
            assign st_c[k+1] = c_q;
            assign st_v[k+1] = v_q;
        end else begin : g_last
            logic             ovf_c;
            logic [WIDTH-1:0] res_c;

            // ovf and cout always describe the unclamped result
            always_comb begin
                ovf_c = (st_a[k][MSB] == st_b[k][MSB]) && (s_next[MSB] != st_a[k][MSB]);
                res_c = s_next;
`ifdef ADDSUB_SATURATE_EN
                if (ovf_c) begin
                    res_c = st_a[k][MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q   <= '0;
                    cout_q  <= 1'b0;
                    ovf_q   <= 1'b0;
                    valid_q <= 1'b0;
                end else if (adv) begin
                    sum_q   <= res_c;
                    cout_q  <= seg_add[SEG];
                    ovf_q   <= ovf_c;
                    valid_q <= st_v[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: 16/4 main instance plus 32/1 and 32/8 sweep instances.
module tb_pipelined_addsub;
    localparam int STAGES = 4;
`ifdef ADDSUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          cyc;
        int          stl;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   stalls;
    exp_t sbq[$];
    vec_t tbl[10];

    pipelined_addsub_if #(.WIDTH(16)) if16 ();
    pipelined_addsub_if #(.WIDTH(32)) if32a ();
    pipelined_addsub_if #(.WIDTH(32)) if32b ();

    pipelined_addsub #(.WIDTH(16), .STAGES(4)) u16  (.clk(clk), .rst_n(rst_n), .bus(if16));
    pipelined_addsub #(.WIDTH(32), .STAGES(1)) u32a (.clk(clk), .rst_n(rst_n), .bus(if32a));
    pipelined_addsub #(.WIDTH(32), .STAGES(8)) u32b (.clk(clk), .rst_n(rst_n), .bus(if32b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        logic [15:0] be;
        logic [16:0] r;
        be  = sub ? ~b : b;
        r   = {1'b0, a} + {1'b0, be} + {16'd0, cin ^ sub};
        e.s = r[15:0];
        e.c = r[16];
        e.o = (a[15] == be[15]) && (r[15] != a[15]);
        if (SAT && e.o) e.s = a[15] ? 16'h8000 : 16'h7FFF;
        e.cyc = 0;
        e.stl = 0;
        return e;
    endfunction

    // Caller is aligned just after a rising edge; returns aligned the same way.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input logic [15:0] es, input logic ec, input logic eo);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        if16.a = a;
        if16.b = b;
        if16.cin = cin;
        if16.op_sub = sub;
        if16.in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (if16.in_ready) begin
                e = '{es, ec, eo, cyc, stalls};
                sbq.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if16.in_valid = 1'b0;
        chk("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_rand();
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        exp_t        e;
        a  = 16'($urandom);
        b  = 16'($urandom);
        ci = 1'($urandom_range(0, 1));
        sb = 1'($urandom_range(0, 1));
        e  = model(a, b, ci, sb);
        send(a, b, ci, sb, e.s, e.c, e.o);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sbq.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    // Monitor: every output-valid cycle is compared against the queue head,
    // so held results during a stall are checked too.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
        end else if (if16.out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_beat actual=out_valid=1 expected=no beat in flight");
            end else begin
                chk("sum", 32'(if16.sum), 32'(sbq[0].s));
                chk("cout", 32'(if16.cout), 32'(sbq[0].c));
                chk("ovf", 32'(if16.ovf), 32'(sbq[0].o));
                if (if16.out_ready) begin
                    chk("latency", 32'(cyc - sbq[0].cyc), 32'(STAGES + stalls - sbq[0].stl));
                    void'(sbq.pop_front());
                end
            end
            if (!if16.out_ready) stalls++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit   done;
        checks = 0;
        errors = 0;
        cyc    = 0;
        stalls = 0;
        done   = 1'b0;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
        tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'h0003, 16'h0004, 1'b1, 1'b0, 16'h0008, 1'b0, 1'b0};
        tbl[6] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
        tbl[7] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[8] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[9] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

        rst_n = 1'b0;
        if16.in_valid = 1'b0;  if16.a = '0;  if16.b = '0;  if16.cin = 1'b0;
        if16.op_sub = 1'b0;    if16.out_ready = 1'b1;
        if32a.in_valid = 1'b0; if32a.a = '0; if32a.b = '0; if32a.cin = 1'b0;
        if32a.op_sub = 1'b0;   if32a.out_ready = 1'b1;
        if32b.in_valid = 1'b0; if32b.a = '0; if32b.b = '0; if32b.cin = 1'b0;
        if32b.op_sub = 1'b0;   if32b.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(if16.out_valid), 32'd0);
        chk("reset_sum", 32'(if16.sum), 32'd0);
        chk("reset_cout", 32'(if16.cout), 32'd0);
        chk("reset_ovf", 32'(if16.ovf), 32'd0);
        chk("reset_in_ready", 32'(if16.in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].s, tbl[i].c, tbl[i].o);
        end
        drain();

        for (int i = 0; i < 1000; i++) send_rand();
        drain();

        // Three-cycle backpressure window in the middle of an 8-beat stream
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand();
            end
            begin
                repeat (5) @(posedge clk);
                #1 if16.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(if16.in_ready), 32'd0);
                    chk("bp_out_valid", 32'(if16.out_valid), 32'd1);
                    @(posedge clk);
                end
                #1 if16.out_ready = 1'b1;
            end
        join
        drain();

        fork
            begin
                for (int i = 0; i < 300; i++) send_rand();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 if16.out_ready = 1'($urandom_range(0, 1));
                end
                if16.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight and the head beat held at the output
        if16.out_ready = 1'b0;
        e = model(16'h8000, 16'hFFFF, 1'b0, 1'b0);
        send(16'h8000, 16'hFFFF, 1'b0, 1'b0, e.s, e.c, e.o);
        send_rand();
        send_rand();
        for (int i = 0; i < 10 && !if16.out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_pre_valid", 32'(if16.out_valid), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(if16.out_valid), 32'd0);
        chk("rst_async_sum", 32'(if16.sum), 32'd0);
        chk("rst_async_cout", 32'(if16.cout), 32'd0);
        chk("rst_async_ovf", 32'(if16.ovf), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        if16.out_ready = 1'b1;
        chk("rst_release_in_ready", 32'(if16.in_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_stale", 32'(if16.out_valid), 32'd0);
        e = model(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, e.s, e.c, e.o);
        drain();

        fork
            begin
                int lat;
                bit seen;
                @(posedge clk);
                #1;
                if32a.a = 32'h0000FFFF; if32a.b = 32'h00000001; if32a.in_valid = 1'b1;
                @(negedge clk);
                chk("w32s1_in_ready", 32'(if32a.in_ready), 32'd1);
                @(posedge clk);
                #1 if32a.in_valid = 1'b0;
                seen = 1'b0;
                lat = 0;
                for (int i = 1; i <= 20 && !seen; i++) begin
                    @(negedge clk);
                    if (if32a.out_valid) begin
                        seen = 1'b1;
                        lat = i;
                    end else begin
                        @(posedge clk);
                    end
                end
                chk("w32s1_latency", 32'(lat), 32'd1);
                chk("w32s1_sum", if32a.sum, 32'h00010000);
                chk("w32s1_cout", 32'(if32a.cout), 32'd0);
            end
            begin
                int lat;
                bit seen;
                @(posedge clk);
                #1;
                if32b.a = 32'h0000FFFF; if32b.b = 32'h00000001; if32b.in_valid = 1'b1;
                @(negedge clk);
                chk("w32s8_in_ready", 32'(if32b.in_ready), 32'd1);
                @(posedge clk);
                #1 if32b.in_valid = 1'b0;
                seen = 1'b0;
                lat = 0;
                for (int i = 1; i <= 20 && !seen; i++) begin
                    @(negedge clk);
                    if (if32b.out_valid) begin
                        seen = 1'b1;
                        lat = i;
                    end else begin
                        @(posedge clk);
                    end
                end
                chk("w32s8_latency", 32'(lat), 32'd8);
                chk("w32s8_sum", if32b.sum, 32'h00010000);
                chk("w32s8_cout", 32'(if32b.cout), 32'd0);
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
